// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer
// Purpose  : Memory-mapped 16-bit interval timer on the CPU bus. Four
//            byte-wide registers at BASE_ADR..BASE_ADR+3. Gives firmware a
//            periodic or one-shot time base and raises an active-low
//            interrupt on counter underflow.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1   system clock (CPU clock)
//   n_reset  in   1   asynchronous active-low reset
//   adr_bus  in  16   CPU address bus
//   data_wr  in   8   CPU write data
//   RW       in   1   1 = read, 0 = write
//   data_rd  out  8   read data, 8'h00 unless selected for read
//   sel      out  1   address decode hit (combinational)
//   n_irq    out  1   active-low interrupt request, ~(IF & IE)
// Register map (offset = adr_bus[1:0])
//   0 CNT_LO  R: counter[7:0]   W: reload[7:0]
//   1 CNT_HI  R: counter[15:8]  W: reload[15:8], load counter, clear IF
//   2 CTRL    R/W: bit0 EN, bit1 CONT, bit2 IE
//   3 STATUS  R: {7'b0, IF}     W: bit0=1 clears IF
// Optional feature
//   TIMER_READ_LATCH_EN : a CNT_LO read snapshots counter[15:8]; CNT_HI
//                         reads then return the snapshot (coherent 16-bit
//                         read). Undefined: CNT_HI reads live counter.
// ============================================================================
module bus_timer #(
  parameter logic [15:0] BASE_ADR = 16'h6000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] adr_bus,
  input  logic [7:0]  data_wr,
  input  logic        RW,
  output logic [7:0]  data_rd,
  output logic        sel,
  output logic        n_irq
);

  localparam logic [7:0] c_presc_last = 8'(PRESCALE - 1);

  if ((PRESCALE < 1) || (PRESCALE > 256)) begin : g_bad_prescale
    $error("bus_timer: PRESCALE must be in 1..256");
  end
  if (BASE_ADR[1:0] != 2'b00) begin : g_bad_base
    $error("bus_timer: BASE_ADR must be 4-byte aligned");
  end

  logic [15:0] r_cnt;
  logic [15:0] r_reload;
  logic [7:0]  r_presc;
  logic        r_en;     // EN doubles as the IDLE(0)/RUN(1) state bit
  logic        r_cont;
  logic        r_ie;
  logic        r_if;

  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_tick;
  logic        w_zero;
  logic        w_unf;
  logic [7:0]  w_cnt_hi_rd;

  assign sel       = (adr_bus[15:2] == BASE_ADR[15:2]);
  assign w_off     = adr_bus[1:0];
  assign w_wr      = sel & ~RW;
  assign w_rd      = sel & RW;
  assign w_wr_lo   = w_wr & (w_off == 2'd0);
  assign w_wr_hi   = w_wr & (w_off == 2'd1);
  assign w_wr_ctrl = w_wr & (w_off == 2'd2);
  assign w_wr_stat = w_wr & (w_off == 2'd3);

  assign w_tick = r_en & (r_presc == c_presc_last);
  assign w_zero = (r_cnt == 16'h0000);
  // A CNT_HI write on the same edge discards the tick entirely.
  assign w_unf  = w_tick & w_zero & ~w_wr_hi;

  // Prescaler: held at zero while stopped; restarted by a counter load so
  // the first period after a CNT_HI write is a full (reload+1)*PRESCALE.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_presc <= 8'h00;
    end else if (w_wr_hi || !r_en || w_tick) begin
      r_presc <= 8'h00;
    end else begin
      r_presc <= r_presc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_reload <= 16'hFFFF;
    end else if (w_wr_lo) begin
      r_reload[7:0] <= data_wr;
    end else if (w_wr_hi) begin
      r_reload[15:8] <= data_wr;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt <= 16'hFFFF;
    end else if (w_wr_hi) begin
      r_cnt <= {data_wr, r_reload[7:0]};
    end else if (w_tick) begin
      if (!w_zero) begin
        r_cnt <= r_cnt - 16'd1;
      end else if (r_cont) begin
        r_cnt <= r_reload;
      end
    end
  end

  // A CTRL write beats the one-shot auto-stop on the same edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_en   <= 1'b0;
      r_cont <= 1'b0;
      r_ie   <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= data_wr[0];
      r_cont <= data_wr[1];
      r_ie   <= data_wr[2];
    end else if (w_unf && !r_cont) begin
      r_en   <= 1'b0;
    end
  end

  // Underflow outranks a STATUS clear so no interrupt is ever lost.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_if <= 1'b0;
    end else if (w_wr_hi) begin
      r_if <= 1'b0;
    end else if (w_unf) begin
      r_if <= 1'b1;
    end else if (w_wr_stat && data_wr[0]) begin
      r_if <= 1'b0;
    end
  end

`ifdef TIMER_READ_LATCH_EN
  logic [7:0] r_hold;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_hold <= 8'hFF;
    end else if (w_rd && (w_off == 2'd0)) begin
      r_hold <= r_cnt[15:8];
    end
  end

  assign w_cnt_hi_rd = r_hold;
`else
  assign w_cnt_hi_rd = r_cnt[15:8];
`endif

  always_comb begin
    data_rd = 8'h00;
    if (w_rd) begin
      case (w_off)
        2'd0:    data_rd = r_cnt[7:0];
        2'd1:    data_rd = w_cnt_hi_rd;
        2'd2:    data_rd = {5'b00000, r_ie, r_cont, r_en};
        default: data_rd = {7'b0000000, r_if};
      endcase
    end
  end

  assign n_irq = ~(r_if & r_ie);

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_timer
// Purpose  : Self-checking bench for bus_timer. Two instances share one bus:
//            u_dut0 (BASE 16'h6000, PRESCALE 1) and u_dut1 (BASE 16'h7000,
//            PRESCALE 4). Expected register values come from a closed-form
//            model: ticks = clocks_since_start / PRESCALE, counter derived
//            arithmetically from ticks and the reload value.
//            Honours TIMER_READ_LATCH_EN for CNT_HI read expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

  logic        clk;
  logic        n_reset;
  logic [15:0] adr_bus;
  logic [7:0]  data_wr;
  logic        RW;
  logic [7:0]  rd0, rd1;
  logic        sel0, sel1;
  logic        nirq0, nirq1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state for the timer currently under test
  int          m_e;      // posedge count at which counting started
  int          m_r;      // reload value
  int          m_p;      // prescale
  bit          m_cont;
  bit          m_ie;
  logic [7:0]  m_hold;   // snapshot register (latch build only)

  bus_timer #(.BASE_ADR(16'h6000), .PRESCALE(1)) u_dut0 (
    .clk(clk), .n_reset(n_reset), .adr_bus(adr_bus), .data_wr(data_wr),
    .RW(RW), .data_rd(rd0), .sel(sel0), .n_irq(nirq0)
  );

  bus_timer #(.BASE_ADR(16'h7000), .PRESCALE(4)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .adr_bus(adr_bus), .data_wr(data_wr),
    .RW(RW), .data_rd(rd1), .sel(sel1), .n_irq(nirq1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] exp_cnt(input int edges);
    int t;
    t = edges / m_p;
    if (m_cont) return 16'(m_r - (t % (m_r + 1)));
    if (t >= m_r) return 16'h0000;
    return 16'(m_r - t);
  endfunction

  function automatic bit exp_if(input int edges);
    return (edges / m_p) >= (m_r + 1);
  endfunction

  function automatic bit exp_en(input int edges);
    if (m_cont) return 1'b1;
    return (edges / m_p) < (m_r + 1);
  endfunction

  // ---------------- bus primitives ----------------
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    adr_bus = addr; data_wr = data; RW = 1'b0;
    @(posedge clk); #1;
    adr_bus = 16'h0000; data_wr = 8'h00; RW = 1'b1;
  endtask

  task automatic bus_read(input int idx, input logic [15:0] addr,
                          output logic [7:0] d, output logic s, output logic q);
    @(negedge clk);
    adr_bus = addr; RW = 1'b1;
    #1;
    d = (idx == 1) ? rd1 : rd0;
    s = (idx == 1) ? sel1 : sel0;
    q = (idx == 1) ? nirq1 : nirq0;
    @(posedge clk); #1;
    adr_bus = 16'h0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic goto_edge(input int n);
    while ((cyc - m_e) < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    n_reset = 1'b0;
    #2;
    n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic start_timer(input int idx, input int r, input logic [7:0] ctrl);
    logic [15:0] base;
    logic [15:0] rr;
    base = (idx == 1) ? 16'h7000 : 16'h6000;
    rr = 16'(r);
    reset_dut();
    bus_write(base, rr[7:0]);
    bus_write(base | 16'h0001, rr[15:8]);
    bus_write(base | 16'h0002, ctrl);
    m_e = cyc; m_r = r; m_p = (idx == 1) ? 4 : 1;
    m_cont = ctrl[1]; m_ie = ctrl[2]; m_hold = 8'hFF;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d; logic s, q;
    reset_dut();
    bus_read(0, 16'h6000, d, s, q);
    checks++; if (d !== 8'hFF || s !== 1'b1) begin failures++; $display("FAIL rst_cnt_lo got=%h sel=%b exp=ff sel=1", d, s); end
    bus_read(0, 16'h6001, d, s, q);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL rst_cnt_hi got=%h exp=ff", d); end
    bus_read(0, 16'h6002, d, s, q);
    checks++; if (d !== 8'h00 || q !== 1'b1) begin failures++; $display("FAIL rst_ctrl got=%h irq=%b exp=00 irq=1", d, q); end
    checks++; if (rd0 !== 8'h00 || sel0 !== 1'b0) begin failures++; $display("FAIL rst_idle_bus rd=%h sel=%b exp=00 sel=0", rd0, sel0); end
    // mid-run reset: get an interrupt pending, then pull reset between edges
    start_timer(0, 0, 8'h07);
    idle(2);
    checks++; if (nirq0 !== 1'b0) begin failures++; $display("FAIL midrun_irq_set got=%b exp=0", nirq0); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if (nirq0 !== 1'b1) begin failures++; $display("FAIL async_reset_irq got=%b exp=1", nirq0); end
    bus_read(0, 16'h6000, d, s, q);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL midrun_cnt_lo got=%h exp=ff", d); end
    bus_read(0, 16'h6001, d, s, q);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL midrun_cnt_hi got=%h exp=ff", d); end
    bus_read(0, 16'h6002, d, s, q);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL midrun_ctrl got=%h exp=00", d); end
    #2 n_reset = 1'b1;
    bus_read(0, 16'h6003, d, s, q);
    checks++; if (d !== 8'h00 || q !== 1'b1) begin failures++; $display("FAIL post_reset_status got=%h irq=%b exp=00 irq=1", d, q); end
  endtask

  task automatic test_periodic();
    logic [7:0] d; logic s, q;
    logic [7:0] seq [5];
    seq[0] = 8'd3; seq[1] = 8'd2; seq[2] = 8'd1; seq[3] = 8'd0; seq[4] = 8'd3;
    start_timer(0, 3, 8'h07);
    for (int k = 0; k < 5; k++) begin
      bus_read(0, 16'h6000, d, s, q);
      checks++; if (d !== seq[k]) begin failures++; $display("FAIL periodic_seq k=%0d got=%h exp=%h", k, d, seq[k]); end
      checks++; if (q !== (k < 4 ? 1'b1 : 1'b0)) begin failures++; $display("FAIL periodic_irq k=%0d got=%b exp=%b", k, q, (k < 4)); end
    end
  endtask

  task automatic test_random(input int idx, input bit cont);
    logic [7:0] d, exp; logic s, q;
    logic [15:0] ec, base;
    int edges, off, r;
    bit ie;
    base = (idx == 1) ? 16'h7000 : 16'h6000;
    for (int t = 0; t < 3; t++) begin
      r  = $urandom_range(0, (idx == 1) ? 4 : 9);
      ie = 1'($urandom_range(0, 1));
      start_timer(idx, r, {5'b00000, ie, cont, 1'b1});
      for (int k = 0; k < 20; k++) begin
        idle($urandom_range(0, 3));
        off   = $urandom_range(0, 3);
        edges = cyc - m_e;
        ec    = exp_cnt(edges);
        case (off)
          0:       exp = ec[7:0];
`ifdef TIMER_READ_LATCH_EN
          1:       exp = m_hold;
`else
          1:       exp = ec[15:8];
`endif
          2:       exp = {5'b00000, m_ie, m_cont, exp_en(edges)};
          default: exp = {7'b0000000, exp_if(edges)};
        endcase
        bus_read(idx, base | 16'(off), d, s, q);
        if (off == 0) m_hold = ec[15:8];
        checks++; if (d !== exp) begin failures++; $display("FAIL rnd_read dut=%0d cont=%0d r=%0d edges=%0d off=%0d got=%h exp=%h", idx, cont, r, edges, off, d, exp); end
        checks++; if (q !== ~(exp_if(edges) & m_ie)) begin failures++; $display("FAIL rnd_irq dut=%0d edges=%0d got=%b exp=%b", idx, edges, q, ~(exp_if(edges) & m_ie)); end
      end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] d; logic s, q;
    start_timer(0, 2, 8'h05);
    goto_edge(2);
    bus_read(0, 16'h6002, d, s, q);
    checks++; if (d !== 8'h05 || q !== 1'b1) begin failures++; $display("FAIL oneshot_pre ctrl=%h irq=%b exp=05 irq=1", d, q); end
    goto_edge(6);
    bus_read(0, 16'h6002, d, s, q);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL oneshot_ctrl got=%h exp=04", d); end
    idle(4);
    bus_read(0, 16'h6000, d, s, q);
    checks++; if (d !== 8'h00 || q !== 1'b0) begin failures++; $display("FAIL oneshot_hold cnt=%h irq=%b exp=00 irq=0", d, q); end
    bus_write(16'h6003, 8'h00);
    bus_read(0, 16'h6003, d, s, q);
    checks++; if (d !== 8'h01 || q !== 1'b0) begin failures++; $display("FAIL status_wr0 got=%h irq=%b exp=01 irq=0", d, q); end
    bus_write(16'h6003, 8'h01);
    bus_read(0, 16'h6003, d, s, q);
    checks++; if (d !== 8'h00 || q !== 1'b1) begin failures++; $display("FAIL status_clear got=%h irq=%b exp=00 irq=1", d, q); end
  endtask

  task automatic test_prescale();
    logic [7:0] d; logic s, q;
    logic [15:0] frozen;
    start_timer(1, 1, 8'h07);
    goto_edge(7);
    bus_read(1, 16'h7003, d, s, q);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL presc_before got=%h exp=00", d); end
    bus_read(1, 16'h7003, d, s, q);
    checks++; if (d !== 8'h01 || q !== 1'b0) begin failures++; $display("FAIL presc_first got=%h irq=%b exp=01 irq=0", d, q); end
    bus_write(16'h7003, 8'h01);
    goto_edge(15);
    bus_read(1, 16'h7003, d, s, q);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL presc_second_before got=%h exp=00", d); end
    bus_read(1, 16'h7003, d, s, q);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL presc_second got=%h exp=01", d); end
    bus_write(16'h7002, 8'h06);
    frozen = exp_cnt(cyc - m_e);
    idle(10);
    bus_read(1, 16'h7000, d, s, q);
    checks++; if (d !== frozen[7:0]) begin failures++; $display("FAIL freeze_cnt got=%h exp=%h", d, frozen[7:0]); end
    idle(7);
    bus_read(1, 16'h7000, d, s, q);
    checks++; if (d !== frozen[7:0]) begin failures++; $display("FAIL freeze_cnt_late got=%h exp=%h", d, frozen[7:0]); end
  endtask

  task automatic test_collision();
    logic [7:0] d; logic s, q;
    // STATUS clear landing on the underflow edge
    start_timer(0, 3, 8'h07);
    goto_edge(3);
    bus_write(16'h6003, 8'h01);
    bus_read(0, 16'h6003, d, s, q);
    checks++; if (d !== 8'h01 || q !== 1'b0) begin failures++; $display("FAIL clr_vs_unf got=%h irq=%b exp=01 irq=0", d, q); end
    bus_write(16'h6003, 8'h01);
    bus_read(0, 16'h6003, d, s, q);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL clr_off_edge got=%h exp=00", d); end
    // CTRL write landing on a one-shot underflow edge keeps EN
    start_timer(0, 1, 8'h05);
    goto_edge(1);
    bus_write(16'h6002, 8'h05);
    bus_read(0, 16'h6002, d, s, q);
    checks++; if (d !== 8'h05 || q !== 1'b0) begin failures++; $display("FAIL ctrl_vs_unf got=%h irq=%b exp=05 irq=0", d, q); end
    bus_read(0, 16'h6002, d, s, q);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL ctrl_vs_unf_after got=%h exp=04", d); end
    // CNT_HI write landing on a tick edge, PRESCALE=4
    start_timer(1, 5, 8'h07);
    goto_edge(24);
    bus_read(1, 16'h7003, d, s, q);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL hi_pre_if got=%h exp=01", d); end
    bus_write(16'h7000, 8'h20);
    goto_edge(27);
    bus_write(16'h7001, 8'h01);
    m_e = cyc; m_r = 16'h0120;
    bus_read(1, 16'h7003, d, s, q);
    checks++; if (d !== 8'h00 || q !== 1'b1) begin failures++; $display("FAIL hi_vs_tick_if got=%h irq=%b exp=00 irq=1", d, q); end
    bus_read(1, 16'h7000, d, s, q);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL hi_vs_tick_lo got=%h exp=20", d); end
    bus_read(1, 16'h7001, d, s, q);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL hi_vs_tick_hi got=%h exp=01", d); end
    bus_read(1, 16'h7000, d, s, q);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL hi_tick3 got=%h exp=20", d); end
    bus_read(1, 16'h7000, d, s, q);
    checks++; if (d !== 8'h1F) begin failures++; $display("FAIL hi_tick4 got=%h exp=1f", d); end
    // CNT_HI write between ticks must restart the prescaler
    bus_write(16'h7001, 8'h01);
    m_e = cyc;
    goto_edge(3);
    bus_read(1, 16'h7000, d, s, q);
    checks++; if (d !== 8'h20) begin failures++; $display("FAIL presc_restart3 got=%h exp=20", d); end
    bus_read(1, 16'h7000, d, s, q);
    checks++; if (d !== 8'h1F) begin failures++; $display("FAIL presc_restart4 got=%h exp=1f", d); end
  endtask

  task automatic test_decode();
    logic [7:0] d; logic s, q;
    logic [15:0] bad [5];
    bad[0] = 16'h6004; bad[1] = 16'h6005; bad[2] = 16'h6006;
    bad[3] = 16'h5FFF; bad[4] = 16'h5FFE;
    reset_dut();
    for (int i = 0; i < 5; i++) bus_write(bad[i], 8'h07);
    bus_read(0, 16'h6004, d, s, q);
    checks++; if (d !== 8'h00 || s !== 1'b0) begin failures++; $display("FAIL decode_p4 rd=%h sel=%b exp=00 sel=0", d, s); end
    bus_read(0, 16'h5FFF, d, s, q);
    checks++; if (d !== 8'h00 || s !== 1'b0) begin failures++; $display("FAIL decode_m1 rd=%h sel=%b exp=00 sel=0", d, s); end
    bus_read(0, 16'h6000, d, s, q);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL decode_cnt_lo got=%h exp=ff", d); end
    bus_read(0, 16'h6002, d, s, q);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL decode_ctrl got=%h exp=00", d); end
    bus_read(0, 16'h6003, d, s, q);
    checks++; if (s !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL decode_top sel=%b rd=%h exp sel=1 rd=00", s, d); end
    // CNT_HI read across a 16'h0100 -> 16'h00FF borrow
    start_timer(0, 16'h0100, 8'h01);
    bus_read(0, 16'h6000, d, s, q);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL latch_lo got=%h exp=00", d); end
    bus_read(0, 16'h6001, d, s, q);
`ifdef TIMER_READ_LATCH_EN
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL latch_hi got=%h exp=01", d); end
`else
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL live_hi got=%h exp=00", d); end
`endif
  endtask

  initial begin
    n_reset = 1'b0;
    adr_bus = 16'h0000;
    data_wr = 8'h00;
    RW      = 1'b1;
    #12 n_reset = 1'b1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_prescale();
    test_collision();
    test_random(0, 1'b1);
    test_random(1, 1'b1);
    test_random(0, 1'b0);
    test_random(1, 1'b0);
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
